uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO: the synthesizable, generalised successor to the bench-side byte-send routine used to stream programs into the CPU's UART loader. It accepts words over a valid/ready handshake, buffers them, and serialises each one onto a single TX line. Data width, stop-bit count, parity mode, baud divisor and FIFO depth are all configurable. It sits beside the CPU top, either as an on-chip program streamer or as a loopback source for the receive path.

---
 rtl/uart_tx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two circular FIFO over a valid/ready handshake.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; o_tx is registered.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 2,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = 4;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST  = NW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    state_t               state;
    state_t               state_next;
    logic [BW-1:0]        baud_cnt;
    logic [BW-1:0]        baud_next;
    logic [NW-1:0]        bit_cnt;
    logic [NW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_q;
    logic                 parity_next;
    logic                 tx_q;
    logic                 tx_next;
    logic                 baud_last;

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign push         = i_valid && !full;
    assign head         = mem[rd_ptr];
    assign head_parity  = ^head;

    assign o_ready      = !full;
    assign o_fifo_count = count;
    assign o_tx         = tx_q;
    assign o_busy       = (state != ST_IDLE);
    assign baud_last    = (baud_cnt == BAUD_LAST);
    assign o_frame_done = (state == ST_STOP) && baud_last && (bit_cnt == STOP_LAST);

    // Storage is flushed logically by the pointer reset, so the array itself needs none.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift_q  <= shift_next;
            parity_q <= parity_next;
            tx_q     <= tx_next;
        end
    end

    // The line level is derived from the state being entered, so o_tx changes on the same edge as the FSM.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_q;
        parity_next = parity_q;
        pop         = 1'b0;
        tx_next     = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    parity_next = (PARITY == 2) ? ~head_parity : head_parity;
                    baud_next   = '0;
                    bit_next    = '0;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = shift_q >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_cnt + NW'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_STOP;
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        bit_next = bit_cnt + NW'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: an 8N2 instance plus 7E1/7O1 instances sharing clock and reset,
// each frame compared bit-for-bit against a reference frame built from the word.
module tb_uart_tx_fifo;

    localparam int CPB        = 4;
    localparam int DEPTH      = 4;
    localparam int NB_M       = 1 + 8 + 0 + 2;
    localparam int NB_P       = 1 + 7 + 1 + 1;
    localparam int F_M        = NB_M * CPB;
    localparam int F_P        = NB_P * CPB;
    localparam int WAIT_LIMIT = 200;

    typedef struct {
        bit          timeout;
        int          start;
        logic [15:0] bits;
        bit          stable;
        int          done_cnt;
        int          done_pos;
        bit          busy_ok;
        bit          idle_ok;
        int          cnt_at_start;
    } frame_t;

    logic       clk;
    logic       rst_n;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_tx;
    logic       m_busy;
    logic       m_done;
    logic [2:0] m_count;

    logic [6:0] p_data;
    logic       p_valid;
    logic       ev_ready;
    logic       ev_tx;
    logic       ev_busy;
    logic       ev_done;
    logic [2:0] ev_count;
    logic       od_ready;
    logic       od_tx;
    logic       od_busy;
    logic       od_done;
    logic [2:0] od_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_data(m_data), .i_valid(m_valid), .o_ready(m_ready),
        .o_tx(m_tx), .o_busy(m_busy), .o_frame_done(m_done), .o_fifo_count(m_count)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(DEPTH)
    ) dut_even (
        .clk(clk), .rst_n(rst_n), .i_data(p_data), .i_valid(p_valid), .o_ready(ev_ready),
        .o_tx(ev_tx), .o_busy(ev_busy), .o_frame_done(ev_done), .o_fifo_count(ev_count)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(DEPTH)
    ) dut_odd (
        .clk(clk), .rst_n(rst_n), .i_data(p_data), .i_valid(p_valid), .o_ready(od_ready),
        .o_tx(od_tx), .o_busy(od_busy), .o_frame_done(od_done), .o_fifo_count(od_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic txOf(input int sel);
        return (sel == 0) ? m_tx : (sel == 1) ? ev_tx : od_tx;
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel == 0) ? m_busy : (sel == 1) ? ev_busy : od_busy;
    endfunction

    function automatic logic doneOf(input int sel);
        return (sel == 0) ? m_done : (sel == 1) ? ev_done : od_done;
    endfunction

    function automatic int countOf(input int sel);
        return (sel == 0) ? int'(m_count) : (sel == 1) ? int'(ev_count) : int'(od_count);
    endfunction

    // Reference frame: index 0 is the start bit, then data LSB first, parity from a ones count, stop bits.
    function automatic logic [15:0] modelFrame(input logic [8:0] word, input int nd, input int pmode, input int ns);
        logic [15:0] f;
        int          pos;
        int          ones;
        f    = '0;
        pos  = 1;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            f[pos] = word[i];
            ones   = ones + int'(word[i]);
            pos++;
        end
        if (pmode == 1) begin
            f[pos] = ((ones % 2) == 1);
            pos++;
        end else if (pmode == 2) begin
            f[pos] = ((ones % 2) == 0);
            pos++;
        end
        for (int i = 0; i < ns; i++) begin
            f[pos] = 1'b1;
            pos++;
        end
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [8:0] d);
        if (sel == 0) begin
            m_data  = d[7:0];
            m_valid = 1'b1;
        end else begin
            p_data  = d[6:0];
            p_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idleInputs(input int sel);
        if (sel == 0) m_valid = 1'b0;
        else          p_valid = 1'b0;
    endtask

    // Waits for the start bit, then samples every cycle of the frame and the idle cycle after it.
    task automatic recvFrame(input int sel, input int nbits, output frame_t fr);
        int  budget;
        logic s;
        fr.timeout      = 1'b0;
        fr.start        = 0;
        fr.bits         = '0;
        fr.stable       = 1'b1;
        fr.done_cnt     = 0;
        fr.done_pos     = -1;
        fr.busy_ok      = 1'b1;
        fr.idle_ok      = 1'b0;
        fr.cnt_at_start = 0;
        budget          = 0;
        while (txOf(sel) !== 1'b0) begin
            if (budget >= WAIT_LIMIT) begin
                fr.timeout = 1'b1;
                return;
            end
            @(negedge clk);
            budget++;
        end
        fr.start        = cyc;
        fr.cnt_at_start = countOf(sel);
        for (int k = 0; k < nbits * CPB; k++) begin
            if (k > 0) @(negedge clk);
            s = txOf(sel);
            if ((k % CPB) == 0) fr.bits[k / CPB] = s;
            else if (s !== fr.bits[k / CPB]) fr.stable = 1'b0;
            if (doneOf(sel) === 1'b1) begin
                fr.done_cnt++;
                fr.done_pos = k;
            end
            if (busyOf(sel) !== 1'b1) fr.busy_ok = 1'b0;
        end
        @(negedge clk);
        fr.idle_ok = (txOf(sel) === 1'b1) && (busyOf(sel) === 1'b0) && (doneOf(sel) === 1'b0);
    endtask

    task automatic checkFrame(input string tag, input frame_t fr, input logic [15:0] exp_bits, input int flen);
        checkOutput({tag, " timeout"},    32'(fr.timeout), 32'd0);
        checkOutput({tag, " bits"},       32'(fr.bits), 32'(exp_bits));
        checkOutput({tag, " stable"},     32'(fr.stable), 32'd1);
        checkOutput({tag, " done count"}, 32'(fr.done_cnt), 32'd1);
        checkOutput({tag, " done pos"},   32'(fr.done_pos), 32'(flen - 1));
        checkOutput({tag, " busy"},       32'(fr.busy_ok), 32'd1);
        checkOutput({tag, " idle after"}, 32'(fr.idle_ok), 32'd1);
    endtask

    initial begin
        frame_t     fr;
        frame_t     fa;
        frame_t     fb;
        frame_t     frames [3];
        logic [8:0] exp_q [$];
        logic [8:0] acc_q [$];
        logic [8:0] obs_q [$];
        logic [8:0] w;
        logic [8:0] r0;
        logic [8:0] r1;
        logic [8:0] sim_w [4];
        int         push_cyc;
        int         mcount;
        int         idle_at;
        int         budget;
        int         bad;
        bit         accept;
        bit         mpop;

        rst_n   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        p_data  = '0;
        p_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset tx",    32'(m_tx), 32'd1);
        checkOutput("reset busy",  32'(m_busy), 32'd0);
        checkOutput("reset done",  32'(m_done), 32'd0);
        checkOutput("reset count", 32'(m_count), 32'd0);
        checkOutput("reset ready", 32'(m_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post-reset tx",   32'(m_tx), 32'd1);
        checkOutput("post-reset busy", 32'(m_busy), 32'd0);

        // Single word: latency and frame shape
        push_cyc = cyc;
        applyStimulus(0, 9'h041);
        idleInputs(0);
        checkOutput("single count n+1", 32'(m_count), 32'd1);
        checkOutput("single tx n+1",    32'(m_tx), 32'd1);
        checkOutput("single busy n+1",  32'(m_busy), 32'd0);
        @(negedge clk);
        checkOutput("single tx n+2",    32'(m_tx), 32'd0);
        checkOutput("single busy n+2",  32'(m_busy), 32'd1);
        checkOutput("single count n+2", 32'(m_count), 32'd0);
        recvFrame(0, NB_M, fr);
        checkOutput("single start latency", 32'(fr.start - push_cyc), 32'd2);
        checkFrame("single", fr, modelFrame(9'h041, 8, 0, 2), F_M);
        checkOutput("single decoded", 32'(fr.bits[8:1]), 32'h41);

        // Back-to-back pushes
        exp_q = '{9'h041, 9'h000, 9'h026};
        fork
            begin
                applyStimulus(0, 9'h041);
                checkOutput("b2b count c1", 32'(m_count), 32'd1);
                applyStimulus(0, 9'h000);
                checkOutput("b2b count c2", 32'(m_count), 32'd1);
                applyStimulus(0, 9'h026);
                idleInputs(0);
                checkOutput("b2b count c3", 32'(m_count), 32'd2);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    recvFrame(0, NB_M, fa);
                    frames[k] = fa;
                end
            end
        join
        for (int k = 0; k < 3; k++) begin
            checkFrame($sformatf("b2b frame%0d", k), frames[k], modelFrame(exp_q[k], 8, 0, 2), F_M);
            if (k > 0) begin
                checkOutput($sformatf("b2b gap%0d", k), 32'(frames[k].start - frames[k-1].start), 32'(F_M + 1));
                checkOutput($sformatf("b2b count at start%0d", k), 32'(frames[k].cnt_at_start), 32'(2 - k));
            end
        end

        // Full boundary: valid held for 10 cycles with random data
        acc_q.delete();
        obs_q.delete();
        mcount  = 0;
        idle_at = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    w      = 9'($urandom_range(0, 255));
                    accept = (mcount < DEPTH);
                    checkOutput($sformatf("full ready c%0d", i), 32'(m_ready), 32'(accept));
                    checkOutput($sformatf("full count c%0d", i), 32'(m_count), 32'(mcount));
                    checkOutput($sformatf("full bound c%0d", i), 32'(m_count <= 3'(DEPTH)), 32'd1);
                    if (accept) acc_q.push_back(w);
                    mpop = (mcount > 0) && (i >= idle_at);
                    if (mpop) idle_at = i + F_M + 1;
                    mcount = mcount + int'(accept) - int'(mpop);
                    applyStimulus(0, w);
                end
                idleInputs(0);
            end
            begin
                do begin
                    recvFrame(0, NB_M, fb);
                    if (obs_q.size() < acc_q.size())
                        checkFrame($sformatf("full frame%0d", obs_q.size()), fb,
                                   modelFrame(acc_q[obs_q.size()], 8, 0, 2), F_M);
                    obs_q.push_back(fb.bits[8:1]);
                end while (!fb.timeout && obs_q.size() < acc_q.size());
            end
        join
        checkOutput("full accepted", 32'(acc_q.size()), 32'(DEPTH + 1));
        checkOutput("full sent", 32'(obs_q.size()), 32'(acc_q.size()));
        bad = 0;
        for (int i = 0; i < 3 * F_M; i++) begin
            if (m_tx !== 1'b1 || m_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("full no extra frames", 32'(bad), 32'd0);

        // Parity and width on 7E1 / 7O1
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      w = 9'h007;
            else if (i == 1) w = 9'h003;
            else             w = 9'($urandom_range(0, 127));
            applyStimulus(1, w);
            idleInputs(1);
            fork
                recvFrame(1, NB_P, fa);
                recvFrame(2, NB_P, fb);
            join
            checkFrame($sformatf("even w%0h", w), fa, modelFrame(w, 7, 1, 1), F_P);
            checkFrame($sformatf("odd w%0h", w), fb, modelFrame(w, 7, 2, 1), F_P);
        end

        // Reset mid-frame
        r0 = 9'($urandom_range(0, 255));
        r1 = 9'($urandom_range(0, 255));
        applyStimulus(0, r0);
        applyStimulus(0, r1);
        idleInputs(0);
        budget = 0;
        while (m_tx !== 1'b0 && budget < WAIT_LIMIT) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("rst start seen", 32'(budget < WAIT_LIMIT), 32'd1);
        repeat (13) @(negedge clk);
        checkOutput("rst pre bit2", 32'(m_tx), 32'(r0[2]));
        checkOutput("rst pre count", 32'(m_count), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst async tx",    32'(m_tx), 32'd1);
        checkOutput("rst async count", 32'(m_count), 32'd0);
        checkOutput("rst async busy",  32'(m_busy), 32'd0);
        checkOutput("rst async ready", 32'(m_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_count !== 3'd0) bad++;
        end
        checkOutput("rst quiet after release", 32'(bad), 32'd0);
        applyStimulus(0, 9'h055);
        idleInputs(0);
        recvFrame(0, NB_M, fr);
        checkFrame("rst fresh 55", fr, modelFrame(9'h055, 8, 0, 2), F_M);

        // Simultaneous push and pop in the inter-frame idle cycle
        for (int i = 0; i < 4; i++) sim_w[i] = 9'($urandom_range(0, 255));
        fork
            begin
                applyStimulus(0, sim_w[0]);
                applyStimulus(0, sim_w[1]);
                applyStimulus(0, sim_w[2]);
                idleInputs(0);
                budget = 0;
                while (m_done !== 1'b1 && budget < WAIT_LIMIT) begin
                    @(negedge clk);
                    budget++;
                end
                checkOutput("sim done seen", 32'(budget < WAIT_LIMIT), 32'd1);
                @(negedge clk);
                checkOutput("sim count before", 32'(m_count), 32'd2);
                applyStimulus(0, sim_w[3]);
                idleInputs(0);
                checkOutput("sim count after", 32'(m_count), 32'd2);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    recvFrame(0, NB_M, fa);
                    checkFrame($sformatf("sim frame%0d", k), fa, modelFrame(sim_w[k], 8, 0, 2), F_M);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
